// File: rtl/controle_votacao.sv
// Day-vote round sequencer: polls living players in index order,
// tallies one vote per voter and reports the eliminated player or a tie.
module controle_votacao #(
  parameter int N_JOGADORES    = 5,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [N_JOGADORES-1:0] vivos,
  input  logic [N_JOGADORES-1:0] botoes_jogadores,
  output logic [2:0]             eleitor_atual,
  output logic                   aguardando_voto,
  output logic                   voto_aceito,
  output logic                   voto_rejeitado,
  output logic                   abstencao,
  output logic                   fim_votacao,
  output logic [2:0]             eliminado,
  output logic                   eliminado_valido
);

  localparam int N  = N_JOGADORES;
  localparam int TW = $clog2(N + 1);
  localparam int CW = $clog2(TIMEOUT_CICLOS);
  localparam logic [3:0]    IDX_N   = 4'(N);
  localparam logic [3:0]    IDX_ULT = 4'(N - 1);
  localparam logic [CW-1:0] T_ULT   = CW'(TIMEOUT_CICLOS - 1);
  localparam logic [N-1:0]  UM      = N'(1);

  typedef enum logic [2:0] {
    OCIOSO, BUSCA, ESPERA_SOLTAR, ESPERA_VOTO, APURA, FIM
  } estado_t;

  estado_t         estado_q, estado_d;
  logic [3:0]      idx_q, idx_d;
  logic [2:0]      eleitor_q, eleitor_d;
  logic [CW-1:0]   timer_q, timer_d;
  logic [N-1:0]    vivos_q, vivos_d;
  logic [TW-1:0]   tally_q [N];
  logic [TW-1:0]   tally_d [N];
  logic [TW-1:0]   max_q, max_d;
  logic [2:0]      arg_q, arg_d;
  logic            tie_q, tie_d;
  logic            aceito_q, aceito_d;
  logic            rejeit_q, rejeit_d;
  logic            abst_q, abst_d;
  logic            fim_q, fim_d;
  logic [2:0]      elim_q, elim_d;
  logic            elim_ok_q, elim_ok_d;

  logic [N-1:0]    self_m;
  logic [N-1:0]    vivos_sh;
  logic            um_bit;
  logic            voto_ok;
  logic [TW-1:0]   cur;

  always_comb begin
    self_m = '0;
    cur    = '0;
    for (int i = 0; i < N; i++) begin
      self_m[i] = (eleitor_q == 3'(i));
      if (idx_q == 4'(i)) cur = tally_q[i];
    end
    vivos_sh = vivos_q >> idx_q;
    um_bit   = (botoes_jogadores != '0) &&
               ((botoes_jogadores & (botoes_jogadores - UM)) == '0);
    voto_ok  = um_bit &&
               ((botoes_jogadores & vivos_q) != '0) &&
               ((botoes_jogadores & self_m) == '0);
  end

  always_comb begin
    estado_d  = estado_q;
    idx_d     = idx_q;
    eleitor_d = eleitor_q;
    timer_d   = timer_q;
    vivos_d   = vivos_q;
    tally_d   = tally_q;
    max_d     = max_q;
    arg_d     = arg_q;
    tie_d     = tie_q;
    elim_d    = elim_q;
    elim_ok_d = elim_ok_q;
    aceito_d  = 1'b0;
    rejeit_d  = 1'b0;
    abst_d    = 1'b0;
    fim_d     = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          vivos_d = vivos;
          for (int i = 0; i < N; i++) tally_d[i] = '0;
          idx_d     = '0;
          elim_d    = '0;
          elim_ok_d = 1'b0;
          estado_d  = BUSCA;
        end
      end
      BUSCA: begin
        if (idx_q == IDX_N) begin
          idx_d    = '0;
          max_d    = '0;
          arg_d    = '0;
          tie_d    = 1'b0;
          estado_d = APURA;
        end else if (vivos_sh[0]) begin
          eleitor_d = idx_q[2:0];
          estado_d  = ESPERA_SOLTAR;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ESPERA_SOLTAR: begin
        // A button still held from the previous voter must not vote.
        if (botoes_jogadores == '0) begin
          timer_d  = '0;
          estado_d = ESPERA_VOTO;
        end
      end
      ESPERA_VOTO: begin
        timer_d = timer_q + CW'(1);
        if (botoes_jogadores != '0) begin
          if (voto_ok) begin
            for (int i = 0; i < N; i++)
              if (botoes_jogadores[i]) tally_d[i] = tally_q[i] + TW'(1);
            aceito_d = 1'b1;
            idx_d    = idx_q + 4'd1;
            estado_d = BUSCA;
          end else begin
            rejeit_d = 1'b1;
            estado_d = ESPERA_SOLTAR;
          end
        end else if (timer_q == T_ULT) begin
          abst_d   = 1'b1;
          idx_d    = idx_q + 4'd1;
          estado_d = BUSCA;
        end
      end
      APURA: begin
        if (cur > max_q) begin
          max_d = cur;
          arg_d = idx_q[2:0];
          tie_d = 1'b0;
        end else if (cur == max_q && max_q != '0) begin
          tie_d = 1'b1;
        end
        if (idx_q == IDX_ULT) begin
          idx_d    = '0;
          estado_d = FIM;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      FIM: begin
        elim_d    = arg_q;
        elim_ok_d = !tie_q && (max_q != '0);
        fim_d     = 1'b1;
        estado_d  = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      idx_q     <= '0;
      eleitor_q <= '0;
      timer_q   <= '0;
      vivos_q   <= '0;
      for (int i = 0; i < N; i++) tally_q[i] <= '0;
      max_q     <= '0;
      arg_q     <= '0;
      tie_q     <= 1'b0;
      aceito_q  <= 1'b0;
      rejeit_q  <= 1'b0;
      abst_q    <= 1'b0;
      fim_q     <= 1'b0;
      elim_q    <= '0;
      elim_ok_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      idx_q     <= idx_d;
      eleitor_q <= eleitor_d;
      timer_q   <= timer_d;
      vivos_q   <= vivos_d;
      tally_q   <= tally_d;
      max_q     <= max_d;
      arg_q     <= arg_d;
      tie_q     <= tie_d;
      aceito_q  <= aceito_d;
      rejeit_q  <= rejeit_d;
      abst_q    <= abst_d;
      fim_q     <= fim_d;
      elim_q    <= elim_d;
      elim_ok_q <= elim_ok_d;
    end
  end

  assign eleitor_atual    = eleitor_q;
  assign aguardando_voto  = (estado_q == ESPERA_VOTO);
  assign voto_aceito      = aceito_q;
  assign voto_rejeitado   = rejeit_q;
  assign abstencao        = abst_q;
  assign fim_votacao      = fim_q;
  assign eliminado        = elim_q;
  assign eliminado_valido = elim_ok_q;

endmodule

// File: tb/tb_controle_votacao.sv
// Bench for controle_votacao: directed and random rounds checked
// against a tally model built from the voting rules.
module tb_controle_votacao;

  localparam int N  = 5;
  localparam int TO = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [4:0] vivos;
  logic [4:0] botoes;
  logic [2:0] eleitor_atual;
  logic       aguardando_voto;
  logic       voto_aceito;
  logic       voto_rejeitado;
  logic       abstencao;
  logic       fim_votacao;
  logic [2:0] eliminado;
  logic       eliminado_valido;

  controle_votacao #(.N_JOGADORES(N), .TIMEOUT_CICLOS(TO)) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .vivos(vivos),
    .botoes_jogadores(botoes),
    .eleitor_atual(eleitor_atual),
    .aguardando_voto(aguardando_voto),
    .voto_aceito(voto_aceito),
    .voto_rejeitado(voto_rejeitado),
    .abstencao(abstencao),
    .fim_votacao(fim_votacao),
    .eliminado(eliminado),
    .eliminado_valido(eliminado_valido)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_acc, n_rej, n_abs, n_fim;

  logic [4:0] m_vivos;
  int m_tally [N];
  int m_acc, m_rej, m_abs;

  always @(negedge clock) begin
    if (voto_aceito)    n_acc++;
    if (voto_rejeitado) n_rej++;
    if (abstencao)      n_abs++;
    if (fim_votacao)    n_fim++;
  end

  function automatic bit valid_vote(logic [4:0] b, logic [4:0] v, int voter);
    return ($countones(b) == 1) && ((b & v) != 0) && !b[voter];
  endfunction

  task automatic wait_aguardo(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (aguardando_voto) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_aguardando: got no ESPERA_VOTO, required one within 40 cycles");
    end
  endtask

  task automatic do_press(input int voter, input logic [4:0] b,
                          input bit hold, output bit acc);
    bit ok;
    bit exp;
    acc = 0;
    wait_aguardo(ok);
    if (!ok) return;
    checks++;
    if (eleitor_atual !== 3'(voter)) begin
      errors++;
      $display("FAIL eleitor: got %0d required %0d", eleitor_atual, voter);
    end
    exp = valid_vote(b, m_vivos, voter);
    botoes = b;
    @(negedge clock);
    checks++;
    if ({voto_aceito, voto_rejeitado} !== {exp, !exp}) begin
      errors++;
      $display("FAIL press v%0d b=%b: aceito/rejeit got %b%b required %b%b",
               voter, b, voto_aceito, voto_rejeitado, exp, !exp);
    end
    if (exp) begin
      for (int i = 0; i < N; i++) if (b[i]) m_tally[i]++;
      m_acc++;
    end else begin
      m_rej++;
    end
    acc = exp;
    if (!hold) botoes = '0;
  endtask

  task automatic do_abstain(input int voter);
    bit ok;
    wait_aguardo(ok);
    if (!ok) return;
    checks++;
    if (eleitor_atual !== 3'(voter)) begin
      errors++;
      $display("FAIL eleitor_abst: got %0d required %0d", eleitor_atual, voter);
    end
    for (int j = 1; j <= TO; j++) begin
      @(negedge clock);
      checks++;
      if (abstencao !== (j == TO) || aguardando_voto !== (j < TO)) begin
        errors++;
        $display("FAIL abst_timing v%0d j=%0d: abst/aguard got %b%b required %b%b",
                 voter, j, abstencao, aguardando_voto, (j == TO), (j < TO));
      end
    end
    m_abs++;
  endtask

  task automatic start_round(input logic [4:0] v);
    @(negedge clock);
    vivos   = v;
    iniciar = 1'b1;
    m_vivos = v;
    foreach (m_tally[i]) m_tally[i] = 0;
    m_acc = 0; m_rej = 0; m_abs = 0;
    n_acc = 0; n_rej = 0; n_abs = 0; n_fim = 0;
    @(negedge clock);
    checks++;
    if ({eliminado, eliminado_valido} !== 4'b0) begin
      errors++;
      $display("FAIL start_clear: elim/valido got %0d/%b required 0/0",
               eliminado, eliminado_valido);
    end
    // Busy start pulse and new alive mask must both be ignored.
    iniciar = 1'b1;
    vivos   = 5'($urandom);
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic finish_round(input string name);
    int mx, arg, cnt;
    bit exp_ok, seen;
    mx = 0; arg = 0; cnt = 0;
    for (int i = 0; i < N; i++)
      if (m_tally[i] > mx) begin mx = m_tally[i]; arg = i; end
    for (int i = 0; i < N; i++) if (m_tally[i] == mx) cnt++;
    exp_ok = (mx > 0) && (cnt == 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (fim_votacao) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s fim: got no fim_votacao, required one", name);
    end else begin
      checks++;
      if (eliminado !== 3'(arg) || eliminado_valido !== exp_ok) begin
        errors++;
        $display("FAIL %s result: got %0d/%b required %0d/%b",
                 name, eliminado, eliminado_valido, arg, exp_ok);
      end
      @(negedge clock);
      checks++;
      if (fim_votacao !== 1'b0 || eliminado !== 3'(arg)) begin
        errors++;
        $display("FAIL %s hold: fim/elim got %b/%0d required 0/%0d",
                 name, fim_votacao, eliminado, arg);
      end
    end
    checks++;
    if (n_acc != m_acc || n_rej != m_rej || n_abs != m_abs || n_fim != 1) begin
      errors++;
      $display("FAIL %s counts: acc/rej/abs/fim got %0d/%0d/%0d/%0d required %0d/%0d/%0d/1",
               name, n_acc, n_rej, n_abs, n_fim, m_acc, m_rej, m_abs);
    end
  endtask

  task automatic vote_list(input int t0, t1, t2, t3, t4);
    int tg [N];
    bit a;
    tg = '{t0, t1, t2, t3, t4};
    for (int v = 0; v < N; v++)
      if (m_vivos[v]) begin
        if (tg[v] < 0) do_abstain(v);
        else do_press(v, 5'(1 << tg[v]), 1'b0, a);
      end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({eleitor_atual, aguardando_voto, voto_aceito, voto_rejeitado, abstencao,
         fim_votacao, eliminado, eliminado_valido} !== 13'b0) begin
      errors++;
      $display("FAIL %s: outputs got %b required all 0", name,
               {eleitor_atual, aguardando_voto, voto_aceito, voto_rejeitado,
                abstencao, fim_votacao, eliminado, eliminado_valido});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b0; vivos = '0; botoes = '0;
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;
  endtask

  task automatic test_majority();
    start_round(5'b11111);
    vote_list(2, 2, 0, 2, 1);
    finish_round("majority");
  endtask

  task automatic test_tie();
    start_round(5'b01111);
    vote_list(1, 0, 1, 0, 3);
    finish_round("tie");
  endtask

  task automatic test_rejects();
    bit a;
    start_round(5'b01111);
    do_press(0, 5'b00100, 1'b0, a);
    do_press(1, 5'b00010, 1'b0, a);
    do_press(1, 5'b01100, 1'b0, a);
    do_press(1, 5'b10000, 1'b0, a);
    do_press(1, 5'b00001, 1'b0, a);
    do_press(2, 5'b00001, 1'b0, a);
    do_press(3, 5'b00001, 1'b0, a);
    finish_round("rejects");
  endtask

  task automatic test_timeout();
    start_round(5'b11111);
    vote_list(-1, -1, -1, -1, -1);
    finish_round("timeout");
  endtask

  task automatic test_held_button();
    bit a;
    start_round(5'b11111);
    do_press(0, 5'b00100, 1'b1, a);
    repeat (10) begin
      @(negedge clock);
      checks++;
      if (aguardando_voto !== 1'b0 || n_acc != 1) begin
        errors++;
        $display("FAIL held: aguard/acc got %b/%0d required 0/1",
                 aguardando_voto, n_acc);
      end
    end
    botoes = '0;
    do_press(1, 5'b00100, 1'b0, a);
    do_press(2, 5'b00010, 1'b0, a);
    do_press(3, 5'b00100, 1'b0, a);
    do_press(4, 5'b00001, 1'b0, a);
    finish_round("held");
  endtask

  task automatic test_reset_mid_round();
    bit a, ok;
    start_round(5'b11111);
    do_press(0, 5'b01000, 1'b0, a);
    do_press(1, 5'b01000, 1'b0, a);
    wait_aguardo(ok);
    reset = 1'b1;
    #1;
    check_zero("reset_async");
    @(negedge clock);
    check_zero("reset_mid");
    reset = 1'b0;
    repeat (15) @(negedge clock);
    checks++;
    if (n_fim != 0 || aguardando_voto !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: fim count/aguard got %0d/%b required 0/0",
               n_fim, aguardando_voto);
    end
    start_round(5'b11111);
    vote_list(4, 4, 0, 1, 2);
    finish_round("after_reset");
  endtask

  task automatic test_random();
    bit a;
    logic [4:0] v, tg;
    int pick;
    for (int r = 0; r < 8; r++) begin
      v = 5'($urandom);
      start_round(v);
      for (int vo = 0; vo < N; vo++) begin
        if (!v[vo]) continue;
        a = 0;
        for (int k = 0; k < 2 && !a; k++)
          do_press(vo, 5'($urandom_range(1, 31)), 1'b0, a);
        if (a) continue;
        tg = v & ~5'(1 << vo);
        if (tg != 0 && $urandom_range(0, 1) == 1) begin
          do begin
            pick = $urandom_range(0, N - 1);
          end while (!tg[pick]);
          do_press(vo, 5'(1 << pick), 1'b0, a);
        end else begin
          do_abstain(vo);
        end
      end
      finish_round("random");
    end
  endtask

  initial begin
    test_reset();
    test_majority();
    test_tie();
    test_rejects();
    test_timeout();
    test_held_button();
    test_reset_mid_round();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
